ysyx_23060208_idu_rx: RTL and testbench

- Receiving end of the IFU->IDU valid/ready channel.
- Accepts {pc, inst} beats from the fetch unit into a 2-entry in-order buffer and decodes the head entry for RV32I format/fields.
- Presents the decoded result to the EXU over a second valid/ready channel.
- Supports a synchronous flush on an EXU control-flow redirect.

---
 rtl/ysyx_23060208_idu_rx.sv | 169 ++++++++++++++++
 tb/tb_ysyx_23060208_idu_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060208_idu_rx.sv
// IDU receive side: 2-entry in-order buffer on the IFU->IDU valid/ready channel,
// with combinational RV32I format/field decode of the head entry toward the EXU.
module ysyx_23060208_idu_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_to_idu_valid,
  input  logic [2*DATA_WIDTH-1:0] ifu_to_idu_data_i,
  output logic                    idu_to_ifu_ready,
  input  logic                    flush,
  output logic                    idu_to_exu_valid,
  input  logic                    exu_to_idu_ready,
  output logic [DATA_WIDTH-1:0]   idu_pc,
  output logic [DATA_WIDTH-1:0]   idu_inst,
  output logic [4:0]              idu_rd,
  output logic [4:0]              idu_rs1,
  output logic [4:0]              idu_rs2,
  output logic [DATA_WIDTH-1:0]   idu_imm,
  output logic [2:0]              idu_type,
  output logic                    idu_illegal,
  output logic [1:0]              dbg_count_o
);

  // Both channels: a beat transfers on a rising edge where valid && ready && !flush.
  // Valid never waits on ready; idu_to_ifu_ready depends only on registered
  // occupancy (and reset), never on exu_to_idu_ready.

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  localparam logic [2:0] TYPE_R   = 3'd0;
  localparam logic [2:0] TYPE_I   = 3'd1;
  localparam logic [2:0] TYPE_S   = 3'd2;
  localparam logic [2:0] TYPE_B   = 3'd3;
  localparam logic [2:0] TYPE_U   = 3'd4;
  localparam logic [2:0] TYPE_J   = 3'd5;
  localparam logic [2:0] TYPE_ILL = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [DATA_WIDTH-1:0] pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0] inst_q [DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head_pc, head_inst;
  logic [6:0]            opcode;

  assign idu_to_ifu_ready = rst && (count_q != FULL_COUNT);
  assign idu_to_exu_valid = (count_q != 2'd0);
  assign dbg_count_o      = count_q;

  assign push = ifu_to_idu_valid && idu_to_ifu_ready && !flush;
  assign pop  = idu_to_exu_valid && exu_to_idu_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        pc_q[wr_ptr_q]   <= ifu_to_idu_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
        inst_q[wr_ptr_q] <= ifu_to_idu_data_i[DATA_WIDTH-1:0];
      end
    end
  end

  assign head_pc   = pc_q[rd_ptr_q];
  assign head_inst = inst_q[rd_ptr_q];
  assign opcode    = head_inst[6:0];

  // Decode outputs are forced to zero whenever the head is empty.
  always_comb begin
    idu_pc      = '0;
    idu_inst    = '0;
    idu_rd      = 5'd0;
    idu_rs1     = 5'd0;
    idu_rs2     = 5'd0;
    idu_imm     = '0;
    idu_type    = 3'd0;
    idu_illegal = 1'b0;
    if (idu_to_exu_valid) begin
      idu_pc   = head_pc;
      idu_inst = head_inst;
      case (opcode)
        OP_LUI, OP_AUIPC: begin
          idu_type = TYPE_U;
          idu_rd   = head_inst[11:7];
          idu_imm  = {{(DATA_WIDTH-31){head_inst[31]}}, head_inst[30:12], 12'b0};
        end
        OP_JAL: begin
          idu_type = TYPE_J;
          idu_rd   = head_inst[11:7];
          idu_imm  = {{(DATA_WIDTH-20){head_inst[31]}}, head_inst[19:12],
                      head_inst[20], head_inst[30:21], 1'b0};
        end
        OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: begin
          idu_type = TYPE_I;
          idu_rd   = head_inst[11:7];
          idu_rs1  = head_inst[19:15];
          idu_imm  = {{(DATA_WIDTH-11){head_inst[31]}}, head_inst[30:20]};
        end
        OP_STORE: begin
          idu_type = TYPE_S;
          idu_rs1  = head_inst[19:15];
          idu_rs2  = head_inst[24:20];
          idu_imm  = {{(DATA_WIDTH-11){head_inst[31]}}, head_inst[30:25], head_inst[11:7]};
        end
        OP_BRANCH: begin
          idu_type = TYPE_B;
          idu_rs1  = head_inst[19:15];
          idu_rs2  = head_inst[24:20];
          idu_imm  = {{(DATA_WIDTH-12){head_inst[31]}}, head_inst[7],
                      head_inst[30:25], head_inst[11:8], 1'b0};
        end
        OP_REG: begin
          idu_type = TYPE_R;
          idu_rd   = head_inst[11:7];
          idu_rs1  = head_inst[19:15];
          idu_rs2  = head_inst[24:20];
        end
        default: begin
          idu_type    = TYPE_ILL;
          idu_illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_idu_rx.sv
// Directed bench for ysyx_23060208_idu_rx: buffering, backpressure, flush,
// decode fields and asynchronous reset, with hand-computed expectations.
module tb_ysyx_23060208_idu_rx;

  logic        clk;
  logic        rst;
  logic        ifu_to_idu_valid;
  logic [63:0] ifu_to_idu_data_i;
  logic        idu_to_ifu_ready;
  logic        flush;
  logic        idu_to_exu_valid;
  logic        exu_to_idu_ready;
  logic [31:0] idu_pc;
  logic [31:0] idu_inst;
  logic [4:0]  idu_rd;
  logic [4:0]  idu_rs1;
  logic [4:0]  idu_rs2;
  logic [31:0] idu_imm;
  logic [2:0]  idu_type;
  logic        idu_illegal;
  logic [1:0]  dbg_count_o;

  int n_total = 0;
  int n_pass  = 0;

  ysyx_23060208_idu_rx #(.DATA_WIDTH(32), .DEPTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .ifu_to_idu_valid  (ifu_to_idu_valid),
    .ifu_to_idu_data_i (ifu_to_idu_data_i),
    .idu_to_ifu_ready  (idu_to_ifu_ready),
    .flush             (flush),
    .idu_to_exu_valid  (idu_to_exu_valid),
    .exu_to_idu_ready  (exu_to_idu_ready),
    .idu_pc            (idu_pc),
    .idu_inst          (idu_inst),
    .idu_rd            (idu_rd),
    .idu_rs1           (idu_rs1),
    .idu_rs2           (idu_rs2),
    .idu_imm           (idu_imm),
    .idu_type          (idu_type),
    .idu_illegal       (idu_illegal),
    .dbg_count_o       (dbg_count_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    ifu_to_idu_valid  = v;
    ifu_to_idu_data_i = {pc, inst};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag, input logic v, input logic r,
                             input logic [1:0] cnt, input logic [31:0] pc);
    check({tag, ".valid"}, 32'(idu_to_exu_valid), 32'(v));
    check({tag, ".ready"}, 32'(idu_to_ifu_ready), 32'(r));
    check({tag, ".count"}, 32'(dbg_count_o), 32'(cnt));
    check({tag, ".pc"},    idu_pc, pc);
  endtask

  task automatic check_dec(input string tag, input logic [2:0] ty, input logic ill,
                           input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
    check({tag, ".type"},    32'(idu_type), 32'(ty));
    check({tag, ".illegal"}, 32'(idu_illegal), 32'(ill));
    check({tag, ".rd"},      32'(idu_rd), 32'(rd));
    check({tag, ".rs1"},     32'(idu_rs1), 32'(rs1));
    check({tag, ".rs2"},     32'(idu_rs2), 32'(rs2));
    check({tag, ".imm"},     idu_imm, imm);
  endtask

  // Push one instruction into an empty buffer, check its decode, then pop it.
  task automatic decode_vec(input string tag, input logic [31:0] inst, input logic [2:0] ty,
                            input logic ill, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    exu_to_idu_ready = 1'b0;
    drive_beat(1'b1, 32'h0000_1000, inst);
    tick();
    drive_beat(1'b0, 32'h0, 32'h0);
    check({tag, ".inst"}, idu_inst, inst);
    check_dec(tag, ty, ill, rd, rs1, rs2, imm);
    exu_to_idu_ready = 1'b1;
    tick();
    exu_to_idu_ready = 1'b0;
    check({tag, ".drained"}, 32'(dbg_count_o), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    exu_to_idu_ready = 1'b0;
    drive_beat(1'b0, 32'h0, 32'h0);

    // Reset state
    #1;
    check_state("reset", 1'b0, 1'b0, 2'd0, 32'h0);
    check_dec("reset", 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_state("released", 1'b0, 1'b1, 2'd0, 32'h0);

    // Single beat, one-cycle latency, then popped
    drive_beat(1'b1, 32'h8000_0000, 32'h0050_0093);
    exu_to_idu_ready = 1'b1;
    tick();
    drive_beat(1'b0, 32'h0, 32'h0);
    check_state("single", 1'b1, 1'b1, 2'd1, 32'h8000_0000);
    check_dec("single", 3'd1, 1'b0, 5'd1, 5'd0, 5'd0, 32'h5);
    tick();
    check_state("single_pop", 1'b0, 1'b1, 2'd0, 32'h0);

    // Backpressure: third beat held while full
    exu_to_idu_ready = 1'b0;
    drive_beat(1'b1, 32'h0, 32'h0000_0013);
    tick();
    check_state("bp1", 1'b1, 1'b1, 2'd1, 32'h0);
    drive_beat(1'b1, 32'h4, 32'h0000_0013);
    tick();
    check_state("bp2", 1'b1, 1'b0, 2'd2, 32'h0);
    drive_beat(1'b1, 32'h8, 32'h0000_0013);
    tick();
    check_state("bp3", 1'b1, 1'b0, 2'd2, 32'h0);
    tick();
    check_state("bp_hold", 1'b1, 1'b0, 2'd2, 32'h0);
    exu_to_idu_ready = 1'b1;
    tick();
    check_state("bp_pop0", 1'b1, 1'b1, 2'd1, 32'h4);
    tick();
    check_state("bp_pop4", 1'b1, 1'b1, 2'd1, 32'h8);

    // Simultaneous push/pop at count=1: one per cycle, strict order
    for (int k = 0; k < 5; k++) begin
      drive_beat(1'b1, 32'h100 + 32'(4 * k), 32'h0000_0013);
      tick();
      check_state($sformatf("stream%0d", k), 1'b1, 1'b1, 2'd1, 32'h100 + 32'(4 * k));
    end
    drive_beat(1'b0, 32'h0, 32'h0);
    tick();
    check_state("stream_end", 1'b0, 1'b1, 2'd0, 32'h0);

    // Flush with a full buffer and an incoming beat
    exu_to_idu_ready = 1'b0;
    drive_beat(1'b1, 32'h30, 32'h0000_0013);
    tick();
    drive_beat(1'b1, 32'h34, 32'h0000_0013);
    tick();
    check_state("pre_flush", 1'b1, 1'b0, 2'd2, 32'h30);
    drive_beat(1'b1, 32'h10, 32'h0000_0013);
    exu_to_idu_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exu_to_idu_ready = 1'b0;
    check_state("flush", 1'b0, 1'b1, 2'd0, 32'h0);
    drive_beat(1'b1, 32'h20, 32'h0000_0013);
    tick();
    drive_beat(1'b0, 32'h0, 32'h0);
    check_state("post_flush", 1'b1, 1'b1, 2'd1, 32'h20);

    // Flush with room: incoming beat dropped and head not consumed-and-replaced
    drive_beat(1'b1, 32'h50, 32'h0000_0013);
    exu_to_idu_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exu_to_idu_ready = 1'b0;
    drive_beat(1'b0, 32'h0, 32'h0);
    check_state("flush_drop", 1'b0, 1'b1, 2'd0, 32'h0);

    // Decode vectors
    decode_vec("dec_b",   32'hFE00_0EE3, 3'd3, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    decode_vec("dec_lui", 32'h1234_5037, 3'd4, 1'b0, 5'd0, 5'd0, 5'd0, 32'h1234_5000);
    decode_vec("dec_ill", 32'h0000_0000, 3'd7, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0);
    decode_vec("dec_r",   32'h0020_81B3, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0);
    decode_vec("dec_s",   32'h0011_2623, 3'd2, 1'b0, 5'd0, 5'd2, 5'd1, 32'd12);
    decode_vec("dec_jal", 32'h0080_00EF, 3'd5, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    decode_vec("dec_ineg", 32'hFFF0_8093, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'hFFFF_FFFF);

    // Asynchronous reset mid-operation
    exu_to_idu_ready = 1'b0;
    drive_beat(1'b1, 32'h60, 32'h0000_0013);
    tick();
    drive_beat(1'b1, 32'h64, 32'h0000_0013);
    tick();
    check_state("pre_rst", 1'b1, 1'b0, 2'd2, 32'h60);
    #2;
    rst = 1'b0;
    #1;
    check_state("async_rst", 1'b0, 1'b0, 2'd0, 32'h0);
    check_dec("async_rst", 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check_state("rst_release", 1'b0, 1'b1, 2'd0, 32'h0);
    drive_beat(1'b0, 32'h0, 32'h0);
    tick();
    check_state("rst_idle", 1'b0, 1'b1, 2'd0, 32'h0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
